// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, per-channel debounce,
// press/release strobes and optional auto-repeat strobes while a button is held.
//
// Handshake: there is no valid/ready pair here. Every output is a registered
// level or a single-cycle strobe that is valid on every clock. A strobe is high
// for exactly the one cycle in which the event is accepted.
module button_conditioner #(
    parameter int CHANNELS        = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = 16000000,
    parameter int REPEAT_PERIOD   = 4000000
) (
    input  logic                    CLK_40M,
    input  logic                    RESET_N,
    input  logic [CHANNELS-1:0]     BTN_RAW,
    output logic [CHANNELS-1:0]     BTN_LEVEL,
    output logic [CHANNELS-1:0]     BTN_PRESS,
    output logic [CHANNELS-1:0]     BTN_RELEASE,
    output logic [CHANNELS-1:0]     BTN_REPEAT,
    output logic [2*CHANNELS-1:0]   dbg_repeat_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
    logic [CHANNELS-1:0] synced;

    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] level_d;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    // Synchroniser chain: the raw pin goes straight into the first flop.
    always_ff @(posedge CLK_40M) begin
        if (!RESET_N) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
        end else begin
            sync_q[0] <= BTN_RAW;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // Debounce: a new level is accepted after DEBOUNCE_CYCLES consecutive
    // differing samples; any agreeing sample restarts the count.
    always_comb begin
        level_d = BTN_LEVEL;
        rise    = '0;
        fall    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            if (synced[i] != BTN_LEVEL[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = synced[i];
                    rise[i]    = synced[i];
                    fall[i]    = ~synced[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Debounce state and level/press/release output registers.
    always_ff @(posedge CLK_40M) begin
        if (!RESET_N) begin
            BTN_LEVEL   <= '0;
            BTN_PRESS   <= '0;
            BTN_RELEASE <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            BTN_LEVEL   <= level_d;
            BTN_PRESS   <= rise;
            BTN_RELEASE <= fall;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    if (REPEAT_EN) begin : g_repeat
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RC_W    = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
        localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
        localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

        typedef enum logic [1:0] {
            RPT_IDLE  = 2'd0,
            RPT_DELAY = 2'd1,
            RPT_RUN   = 2'd2
        } rpt_state_t;

        rpt_state_t          state_q [CHANNELS];
        rpt_state_t          state_d [CHANNELS];
        logic [RC_W-1:0]     rc_q [CHANNELS];
        logic [RC_W-1:0]     rc_d [CHANNELS];
        logic [CHANNELS-1:0] rep_d;

        // Repeat FSM state, counters and the registered repeat strobe.
        always_ff @(posedge CLK_40M) begin
            if (!RESET_N) begin
                BTN_REPEAT <= '0;
                for (int i = 0; i < CHANNELS; i++) begin
                    state_q[i] <= RPT_IDLE;
                    rc_q[i]    <= '0;
                end
            end else begin
                BTN_REPEAT <= rep_d;
                for (int i = 0; i < CHANNELS; i++) begin
                    state_q[i] <= state_d[i];
                    rc_q[i]    <= rc_d[i];
                end
            end
        end

        // Next state: the accepted release wins over a repeat falling due in the same cycle.
        always_comb begin
            rep_d = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_d[i] = state_q[i];
                rc_d[i]    = rc_q[i];
                case (state_q[i])
                    RPT_IDLE: begin
                        if (rise[i]) begin
                            state_d[i] = RPT_DELAY;
                            rc_d[i]    = '0;
                        end
                    end
                    RPT_DELAY: begin
                        if (fall[i]) begin
                            state_d[i] = RPT_IDLE;
                            rc_d[i]    = '0;
                        end else if (rc_q[i] == DELAY_LAST) begin
                            rep_d[i]   = 1'b1;
                            rc_d[i]    = '0;
                            state_d[i] = RPT_RUN;
                        end else begin
                            rc_d[i] = rc_q[i] + RC_W'(1);
                        end
                    end
                    RPT_RUN: begin
                        if (fall[i]) begin
                            state_d[i] = RPT_IDLE;
                            rc_d[i]    = '0;
                        end else if (rc_q[i] == PERIOD_LAST) begin
                            rep_d[i] = 1'b1;
                            rc_d[i]  = '0;
                        end else begin
                            rc_d[i] = rc_q[i] + RC_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = RPT_IDLE;
                        rc_d[i]    = '0;
                    end
                endcase
            end
        end

        // Expose each channel's repeat state, two bits per channel.
        always_comb begin
            dbg_repeat_state = '0;
            for (int i = 0; i < CHANNELS; i++) begin
                dbg_repeat_state[2*i +: 2] = state_q[i];
            end
        end
    end else begin : g_no_repeat
        assign BTN_REPEAT       = '0;
        assign dbg_repeat_state = '0;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity,
// every output cycle compared against a behavioural model through an expected queue.
module tb_button_conditioner;

    localparam int CH   = 2;
    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int RD   = 20;
    localparam int RP   = 5;
    localparam int W    = 4 * CH;

    logic            clk;
    logic            rst_n;
    logic [CH-1:0]   btn_raw;
    logic [CH-1:0]   btn_level;
    logic [CH-1:0]   btn_press;
    logic [CH-1:0]   btn_release;
    logic [CH-1:0]   btn_repeat;
    logic [2*CH-1:0] dbg_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        int cyc;
        int ch;
        int kind;   // 0 press, 1 release, 2 repeat
    } ev_t;
    ev_t ev_log[$];

    // model state
    logic [CH-1:0] raw_q[$];
    logic [CH-1:0] m_level;
    int            m_run [CH];
    bit            m_held [CH];
    int            m_age [CH];

    button_conditioner #(
        .CHANNELS        (CH),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_EN       (1'b1),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .CLK_40M          (clk),
        .RESET_N          (rst_n),
        .BTN_RAW          (btn_raw),
        .BTN_LEVEL        (btn_level),
        .BTN_PRESS        (btn_press),
        .BTN_RELEASE      (btn_release),
        .BTN_REPEAT       (btn_repeat),
        .dbg_repeat_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int ev_cycle(input int kind, input int ch, input int n);
        int k = 0;
        foreach (ev_log[i]) begin
            if (ev_log[i].kind == kind && ev_log[i].ch == ch) begin
                if (k == n) return ev_log[i].cyc;
                k++;
            end
        end
        return -1;
    endfunction

    function automatic int ev_count(input int kind, input int ch);
        int k = 0;
        foreach (ev_log[i]) begin
            if (ev_log[i].kind == kind && ev_log[i].ch == ch) k++;
        end
        return k;
    endfunction

    // Reference model: the synced sample is the raw pin seen SYNC edges earlier;
    // a level flips after DEB consecutive differing samples; repeats fall due when
    // the time since press reaches RD and then every RP cycles after that.
    task automatic model_step();
        logic [CH-1:0] s;
        logic [CH-1:0] pr;
        logic [CH-1:0] rl;
        logic [CH-1:0] rp;
        pr = '0;
        rl = '0;
        rp = '0;
        cyc = cyc + 1;
        if (!rst_n) begin
            raw_q.delete();
            for (int j = 0; j < SYNC; j++) raw_q.push_back('0);
            m_level = '0;
            for (int c = 0; c < CH; c++) begin
                m_run[c]  = 0;
                m_held[c] = 1'b0;
                m_age[c]  = 0;
            end
        end else begin
            s = raw_q.pop_front();
            raw_q.push_back(btn_raw);
            for (int c = 0; c < CH; c++) begin
                bit accepted = 1'b0;
                if (s[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB) begin
                        accepted = 1'b1;
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (accepted) begin
                    m_level[c] = s[c];
                    if (s[c]) begin
                        pr[c]     = 1'b1;
                        m_held[c] = 1'b1;
                        m_age[c]  = 0;
                    end else begin
                        rl[c]     = 1'b1;
                        m_held[c] = 1'b0;
                    end
                end else if (m_held[c]) begin
                    m_age[c]++;
                    if (m_age[c] >= RD && ((m_age[c] - RD) % RP) == 0) rp[c] = 1'b1;
                end
            end
        end
        exp_q.push_back({m_level, pr, rl, rp});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // scoreboard monitor: pops one expected output word per cycle
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL exp_q_underflow cyc=%0d actual=empty required=entry", cyc);
            end else begin
                logic [W-1:0] exp_v;
                logic [W-1:0] act_v;
                exp_v = exp_q.pop_front();
                act_v = {btn_level, btn_press, btn_release, btn_repeat};
                checks++;
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d actual=%b required=%b", cyc, act_v, exp_v);
                end
                for (int c = 0; c < CH; c++) begin
                    ev_t e;
                    e.cyc = cyc;
                    e.ch  = c;
                    if (btn_press[c] === 1'b1)   begin e.kind = 0; ev_log.push_back(e); end
                    if (btn_release[c] === 1'b1) begin e.kind = 1; ev_log.push_back(e); end
                    if (btn_repeat[c] === 1'b1)  begin e.kind = 2; ev_log.push_back(e); end
                end
            end
        end
    end

    // driver sequence
    initial begin
        int k;
        int p;
        int r0;
        int kr;

        // 1: reset with both buttons held, then fresh press after release of reset
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        wait_cycles(3);
        check("t1_dbg_reset", int'(dbg_state), 0);
        check("t1_no_events_in_reset", ev_log.size(), 0);
        rst_n = 1'b1;
        r0 = cyc;
        wait_cycles(15);
        check("t1_press_ch0", ev_cycle(0, 0, 0), r0 + 10);
        check("t1_press_ch1", ev_cycle(0, 1, 0), r0 + 10);
        check("t1_press_total", ev_count(0, 0) + ev_count(0, 1), 2);
        btn_raw = 2'b00;
        wait_cycles(20);

        // 2: clean press and release on ch0, ch1 idle
        ev_log.delete();
        k = cyc;
        btn_raw[0] = 1'b1;
        wait_cycles(15);
        check("t2_press_ch0", ev_cycle(0, 0, 0), k + 10);
        check("t2_press_ch0_count", ev_count(0, 0), 1);
        k = cyc;
        btn_raw[0] = 1'b0;
        wait_cycles(15);
        check("t2_release_ch0", ev_cycle(1, 0, 0), k + 10);
        check("t2_ch1_untouched", ev_count(0, 1) + ev_count(1, 1) + ev_count(2, 1), 0);

        // 3: bouncing contact, then a stable press
        ev_log.delete();
        for (int i = 0; i < 14; i++) begin
            btn_raw[0] = ~btn_raw[0];
            wait_cycles(3);
        end
        check("t3_press_during_bounce", ev_count(0, 0), 0);
        k = cyc;
        btn_raw[0] = 1'b1;
        wait_cycles(15);
        check("t3_press_after_bounce", ev_cycle(0, 0, 0), k + 10);
        check("t3_press_count", ev_count(0, 0), 1);
        check("t3_release_count", ev_count(1, 0), 0);
        btn_raw[0] = 1'b0;
        wait_cycles(20);

        // 4: auto-repeat on ch1, then release stops it
        ev_log.delete();
        k = cyc;
        p = k + 10;
        btn_raw[1] = 1'b1;
        wait_cycles(42);
        kr = cyc;
        btn_raw[1] = 1'b0;
        wait_cycles(40);
        check("t4_press", ev_cycle(0, 1, 0), p);
        check("t4_repeat0", ev_cycle(2, 1, 0), p + 20);
        check("t4_repeat1", ev_cycle(2, 1, 1), p + 25);
        check("t4_repeat2", ev_cycle(2, 1, 2), p + 30);
        check("t4_release", ev_cycle(1, 1, 0), kr + 10);
        check("t4_repeat_count", ev_count(2, 1), 5);

        // 5: release accepted on the cycle a repeat falls due
        ev_log.delete();
        k = cyc;
        p = k + 10;
        btn_raw[0] = 1'b1;
        wait_cycles(30);
        btn_raw[0] = 1'b0;
        wait_cycles(30);
        check("t5_release", ev_cycle(1, 0, 0), p + 30);
        check("t5_repeat_count", ev_count(2, 0), 2);
        check("t5_repeat1", ev_cycle(2, 0, 1), p + 25);

        // 6: reset while repeating with the button held
        ev_log.delete();
        k = cyc;
        p = k + 10;
        btn_raw[1] = 1'b1;
        wait_cycles(33);
        rst_n = 1'b0;
        wait_cycles(1);
        rst_n = 1'b1;
        r0 = cyc;
        wait_cycles(40);
        check("t6_repeat_before_reset", ev_cycle(2, 1, 0), p + 20);
        check("t6_press_after_reset", ev_cycle(0, 1, 1), r0 + 10);
        check("t6_repeat_after_reset", ev_cycle(2, 1, 1), r0 + 30);
        btn_raw = 2'b00;
        wait_cycles(20);

        // random activity on both channels with occasional resets
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                wait_cycles($urandom_range(1, 2));
                rst_n = 1'b1;
            end
            btn_raw = 2'($urandom_range(0, 3));
            wait_cycles($urandom_range(1, 35));
        end
        btn_raw = 2'b00;
        wait_cycles(20);

        // final report
        #6;
        check("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
